// File: rtl/bram_req_if.sv
// One requester's port into the shared block RAM.
// The requester drives the request and receives the read response back.
interface bram_req_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
);
  logic                     valid;
  logic                     ready;
  logic                     wen;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;

  modport master (
    output valid, wen, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, wen, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one single-read/single-write block RAM between two requesters,
// with independent round-robin read and write arbitration and a memory clear.
//
// state | meaning
// IDLE  | serve requests; reads and writes arbitrated independently
// CLEAR | write zero to every address, one per cycle; requests stalled
module bram_port_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear_start,
  output logic                     clear_busy,
  bram_req_if.slave                req0,
  bram_req_if.slave                req1,
  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     mem_wen,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_din
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clear_addr_q, clear_addr_d;
  logic                     rd_prio_q, wr_prio_q;
  logic [ADDRESS_WIDTH-1:0] raddr_q;
  logic [1:0]               rsp_pend_q;
  logic [1:0]               rd_cand, wr_cand;
  logic [1:0]               rd_gnt, wr_gnt;
  logic [1:0]               rd_sel, wr_sel;

  assign rd_cand = {req1.valid & ~req1.wen, req0.valid & ~req0.wen};
  assign wr_cand = {req1.valid &  req1.wen, req0.valid &  req0.wen};

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    rd_gnt       = '0;
    wr_gnt       = '0;
    unique case (state_q)
      IDLE: begin
        if (clear_start) state_d = CLEAR;
        rd_gnt[1] = rd_cand[1] & (~rd_cand[0] | rd_prio_q);
        rd_gnt[0] = rd_cand[0] & ~rd_gnt[1];
        wr_gnt[1] = wr_cand[1] & (~wr_cand[0] | wr_prio_q);
        wr_gnt[0] = wr_cand[0] & ~wr_gnt[1];
      end
      CLEAR: begin
        clear_addr_d = clear_addr_q + ADDRESS_WIDTH'(1);
        if (&clear_addr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants seen outside the block are held off while reset is asserted;
  // the raw grants only feed flops that are themselves held in reset.
  assign rd_sel = reset_n ? rd_gnt : 2'b00;
  assign wr_sel = reset_n ? wr_gnt : 2'b00;

  assign clear_busy = (state_q == CLEAR);
  assign req0.ready = rd_sel[0] | wr_sel[0];
  assign req1.ready = rd_sel[1] | wr_sel[1];

  assign mem_raddr = rd_sel[1] ? req1.addr :
                     rd_sel[0] ? req0.addr : raddr_q;
  assign mem_wen   = clear_busy | (|wr_sel);
  assign mem_waddr = clear_busy ? clear_addr_q :
                     wr_sel[1]  ? req1.addr    :
                     wr_sel[0]  ? req0.addr    : '0;
  assign mem_din   = wr_sel[1]  ? req1.wdata   :
                     wr_sel[0]  ? req0.wdata   : '0;

  assign req0.rsp_valid = rsp_pend_q[0];
  assign req1.rsp_valid = rsp_pend_q[1];
  assign req0.rsp_rdata = rsp_pend_q[0] ? mem_dout : '0;
  assign req1.rsp_rdata = rsp_pend_q[1] ? mem_dout : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clear_addr_q <= '0;
      rd_prio_q    <= 1'b0;
      wr_prio_q    <= 1'b0;
      raddr_q      <= '0;
      rsp_pend_q   <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      rsp_pend_q   <= rd_gnt;
      if (|rd_gnt) begin
        rd_prio_q <= rd_gnt[0];
        raddr_q   <= rd_gnt[1] ? req1.addr : req0.addr;
      end
      if (|wr_gnt) wr_prio_q <= wr_gnt[0];
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a 16-word block RAM model
// (1-cycle read latency, read-first on collision).
module tb_bram_port_arbiter;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clock       = 1'b0;
  logic          reset_n     = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_dout;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_din;

  bram_req_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) req0_if ();
  bram_req_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) req1_if ();

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .req0        (req0_if),
    .req1        (req1_if),
    .mem_raddr   (mem_raddr),
    .mem_dout    (mem_dout),
    .mem_wen     (mem_wen),
    .mem_waddr   (mem_waddr),
    .mem_din     (mem_din)
  );

  always #5 clock = ~clock;

  // memory model with a backdoor: 1 = one word, 2 = ramp fill, 3 = constant fill
  logic [DW-1:0] mem [DEPTH];
  logic [1:0]    bd_op   = 2'd0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clock) begin
    mem_dout <= mem[mem_raddr];
    if (mem_wen) mem[mem_waddr] <= mem_din;
    case (bd_op)
      2'd1: mem[bd_addr] <= bd_data;
      2'd2: for (int i = 0; i < DEPTH; i++) mem[i] <= bd_data + DW'(i);
      2'd3: for (int i = 0; i < DEPTH; i++) mem[i] <= bd_data;
      default: ;
    endcase
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic set_req(input int n, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      req0_if.valid = v; req0_if.wen = w; req0_if.addr = a; req0_if.wdata = d;
    end else begin
      req1_if.valid = v; req1_if.wen = w; req1_if.addr = a; req1_if.wdata = d;
    end
  endtask

  task automatic idle_reqs();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic backdoor(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    bd_op = op; bd_addr = a; bd_data = d;
    @(negedge clock);
    bd_op = 2'd0;
  endtask

  typedef struct {
    logic v0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic v1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic e_r0, e_r1, e_wen; logic [AW-1:0] e_waddr; logic [DW-1:0] e_din;
    logic [AW-1:0] e_raddr;
    logic e_rv0, e_rv1; logic [DW-1:0] e_rd0, e_rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic v0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic v1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic r0, r1, wen, input logic [AW-1:0] waddr, input logic [DW-1:0] din,
    input logic [AW-1:0] raddr, input logic rv0, rv1, input logic [DW-1:0] rd0, rd1);
    vec_t t;
    t.v0 = v0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.v1 = v1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.e_r0 = r0; t.e_r1 = r1; t.e_wen = wen; t.e_waddr = waddr; t.e_din = din;
    t.e_raddr = raddr; t.e_rv0 = rv0; t.e_rv1 = rv1; t.e_rd0 = rd0; t.e_rd1 = rd1;
    return t;
  endfunction

  vec_t vecs[9];

  initial begin
    logic [AW-1:0] k4;
    int bad;

    // memory preloaded with 0xA000+addr; priorities start at requester 0
    vecs[0] = mk(1'b1,1'b0,4'd3,16'h0,     1'b0,1'b0,4'd0,16'h0,     1'b1,1'b0,1'b0,4'd0,16'h0,     4'd3,  1'b0,1'b0,16'h0,16'h0);
    vecs[1] = mk(1'b1,1'b0,4'd4,16'h0,     1'b1,1'b0,4'd5,16'h0,     1'b0,1'b1,1'b0,4'd0,16'h0,     4'd5,  1'b1,1'b0,16'hA003,16'h0);
    vecs[2] = mk(1'b1,1'b0,4'd6,16'h0,     1'b1,1'b0,4'd7,16'h0,     1'b1,1'b0,1'b0,4'd0,16'h0,     4'd6,  1'b0,1'b1,16'h0,16'hA005);
    vecs[3] = mk(1'b1,1'b1,4'd8,16'h1111,  1'b1,1'b1,4'd9,16'h2222,  1'b1,1'b0,1'b1,4'd8,16'h1111,  4'd6,  1'b1,1'b0,16'hA006,16'h0);
    vecs[4] = mk(1'b1,1'b1,4'd10,16'h3333, 1'b1,1'b0,4'd11,16'h0,    1'b1,1'b1,1'b1,4'd10,16'h3333, 4'd11, 1'b0,1'b0,16'h0,16'h0);
    vecs[5] = mk(1'b1,1'b1,4'd12,16'h4444, 1'b1,1'b1,4'd13,16'h5555, 1'b0,1'b1,1'b1,4'd13,16'h5555, 4'd11, 1'b0,1'b1,16'h0,16'hA00B);
    vecs[6] = mk(1'b0,1'b0,4'd0,16'h0,     1'b0,1'b0,4'd0,16'h0,     1'b0,1'b0,1'b0,4'd0,16'h0,     4'd11, 1'b0,1'b0,16'h0,16'h0);
    vecs[7] = mk(1'b1,1'b1,4'd2,16'h6666,  1'b1,1'b0,4'd2,16'h0,     1'b1,1'b1,1'b1,4'd2,16'h6666,  4'd2,  1'b0,1'b0,16'h0,16'h0);
    vecs[8] = mk(1'b0,1'b0,4'd0,16'h0,     1'b0,1'b0,4'd0,16'h0,     1'b0,1'b0,1'b0,4'd0,16'h0,     4'd2,  1'b0,1'b1,16'h0,16'hA002);

    // reset with requests presented
    set_req(0, 1'b1, 1'b0, 4'd3, 16'h0);
    set_req(1, 1'b1, 1'b1, 4'd4, 16'h9999);
    #2;
    chk("rst_ready0", 32'(req0_if.ready), 32'd0);
    chk("rst_ready1", 32'(req1_if.ready), 32'd0);
    chk("rst_wen",    32'(mem_wen),       32'd0);
    chk("rst_busy",   32'(clear_busy),    32'd0);
    chk("rst_rsp0",   32'(req0_if.rsp_valid), 32'd0);
    chk("rst_rsp1",   32'(req1_if.rsp_valid), 32'd0);
    chk("rst_rdata0", 32'(req0_if.rsp_rdata), 32'd0);
    chk("rst_raddr",  32'(mem_raddr),     32'd0);
    backdoor(2'd2, '0, 16'hA000);
    #1;
    chk("rst_hold_ready0", 32'(req0_if.ready), 32'd0);
    chk("rst_hold_wen",    32'(mem_wen),       32'd0);
    idle_reqs();
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      set_req(0, vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0);
      set_req(1, vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d_ready0", i), 32'(req0_if.ready), 32'(vecs[i].e_r0));
      chk($sformatf("v%0d_ready1", i), 32'(req1_if.ready), 32'(vecs[i].e_r1));
      chk($sformatf("v%0d_wen", i),    32'(mem_wen),       32'(vecs[i].e_wen));
      chk($sformatf("v%0d_waddr", i),  32'(mem_waddr),     32'(vecs[i].e_waddr));
      chk($sformatf("v%0d_din", i),    32'(mem_din),       32'(vecs[i].e_din));
      chk($sformatf("v%0d_raddr", i),  32'(mem_raddr),     32'(vecs[i].e_raddr));
      chk($sformatf("v%0d_rv0", i),    32'(req0_if.rsp_valid), 32'(vecs[i].e_rv0));
      chk($sformatf("v%0d_rv1", i),    32'(req1_if.rsp_valid), 32'(vecs[i].e_rv1));
      chk($sformatf("v%0d_rd0", i),    32'(req0_if.rsp_rdata), 32'(vecs[i].e_rd0));
      chk($sformatf("v%0d_rd1", i),    32'(req1_if.rsp_rdata), 32'(vecs[i].e_rd1));
    end
    @(negedge clock);
    idle_reqs();
    chk("mem8",  32'(mem[8]),  32'h1111);
    chk("mem9",  32'(mem[9]),  32'hA009);
    chk("mem10", 32'(mem[10]), 32'h3333);
    chk("mem12", 32'(mem[12]), 32'hA00C);
    chk("mem13", 32'(mem[13]), 32'h5555);
    chk("mem2",  32'(mem[2]),  32'h6666);

    // single read
    backdoor(2'd1, 4'd5, 16'h1234);
    set_req(0, 1'b1, 1'b0, 4'd5, 16'h0);
    #1;
    chk("sr_ready0", 32'(req0_if.ready), 32'd1);
    chk("sr_ready1", 32'(req1_if.ready), 32'd0);
    @(negedge clock);
    idle_reqs();
    #1;
    chk("sr_rv0", 32'(req0_if.rsp_valid), 32'd1);
    chk("sr_rd0", 32'(req0_if.rsp_rdata), 32'h1234);
    chk("sr_rv1", 32'(req1_if.rsp_valid), 32'd0);

    // contention from reset: grants alternate starting at requester 0
    @(negedge clock);
    reset_n = 1'b0;
    bd_op = 2'd1; bd_addr = 4'd1; bd_data = 16'hAAAA;
    @(negedge clock);
    bd_addr = 4'd2; bd_data = 16'hBBBB;
    @(negedge clock);
    bd_op = 2'd0;
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      if (k < 6) begin
        set_req(0, 1'b1, 1'b0, 4'd1, 16'h0);
        set_req(1, 1'b1, 1'b0, 4'd2, 16'h0);
      end else idle_reqs();
      #1;
      chk($sformatf("ct%0d_ready0", k), 32'(req0_if.ready), 32'((k < 6) && (k % 2 == 0)));
      chk($sformatf("ct%0d_ready1", k), 32'(req1_if.ready), 32'((k < 6) && (k % 2 == 1)));
      chk($sformatf("ct%0d_rv0", k), 32'(req0_if.rsp_valid), 32'((k > 0) && ((k - 1) % 2 == 0)));
      chk($sformatf("ct%0d_rv1", k), 32'(req1_if.rsp_valid), 32'((k > 0) && ((k - 1) % 2 == 1)));
      chk($sformatf("ct%0d_rd0", k), 32'(req0_if.rsp_rdata), ((k > 0) && ((k - 1) % 2 == 0)) ? 32'hAAAA : 32'h0);
      chk($sformatf("ct%0d_rd1", k), 32'(req1_if.rsp_rdata), ((k > 0) && ((k - 1) % 2 == 1)) ? 32'hBBBB : 32'h0);
    end

    // parallel write and read of the same address: read-first
    backdoor(2'd1, 4'd7, 16'h5555);
    set_req(0, 1'b1, 1'b1, 4'd7, 16'h00FF);
    set_req(1, 1'b1, 1'b0, 4'd7, 16'h0);
    #1;
    chk("po_ready0", 32'(req0_if.ready), 32'd1);
    chk("po_ready1", 32'(req1_if.ready), 32'd1);
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 4'd7, 16'h0);
    set_req(1, 1'b0, 1'b0, 4'd0, 16'h0);
    #1;
    chk("po_rv1", 32'(req1_if.rsp_valid), 32'd1);
    chk("po_rd1", 32'(req1_if.rsp_rdata), 32'h5555);
    chk("po_rv0", 32'(req0_if.rsp_valid), 32'd0);
    @(negedge clock);
    idle_reqs();
    #1;
    chk("po_new_rd0", 32'(req0_if.rsp_rdata), 32'h00FF);

    // full clear with a request held throughout and a re-pulse mid-clear
    backdoor(2'd3, '0, 16'hFFFF);
    clear_start = 1'b1;
    #1;
    chk("cl_busy_pre", 32'(clear_busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      clear_start = (k == 5);
      set_req(0, 1'b1, 1'b0, 4'd3, 16'h0);
      k4 = AW'(k);
      #1;
      chk($sformatf("cl%0d_busy", k),   32'(clear_busy),    32'd1);
      chk($sformatf("cl%0d_wen", k),    32'(mem_wen),       32'd1);
      chk($sformatf("cl%0d_waddr", k),  32'(mem_waddr),     32'(k4));
      chk($sformatf("cl%0d_din", k),    32'(mem_din),       32'd0);
      chk($sformatf("cl%0d_ready0", k), 32'(req0_if.ready), 32'd0);
    end
    @(negedge clock);
    clear_start = 1'b0;
    #1;
    chk("cl_end_busy",   32'(clear_busy),    32'd0);
    chk("cl_end_ready0", 32'(req0_if.ready), 32'd1);
    chk("cl_end_raddr",  32'(mem_raddr),     32'd3);
    @(negedge clock);
    idle_reqs();
    #1;
    chk("cl_rv0", 32'(req0_if.rsp_valid), 32'd1);
    chk("cl_rd0", 32'(req0_if.rsp_rdata), 32'd0);
    chk("cl_busy_after", 32'(clear_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 16'h0) bad++;
    chk("cl_mem_nonzero_words", 32'(bad), 32'd0);

    // reset while clearing address 6
    backdoor(2'd3, '0, 16'hFFFF);
    clear_start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      clear_start = 1'b0;
    end
    set_req(0, 1'b1, 1'b0, 4'd1, 16'h0);
    set_req(1, 1'b1, 1'b1, 4'd2, 16'h1234);
    #1;
    chk("rm_waddr6", 32'(mem_waddr), 32'd6);
    reset_n = 1'b0;
    #1;
    chk("rm_busy",   32'(clear_busy),    32'd0);
    chk("rm_ready0", 32'(req0_if.ready), 32'd0);
    chk("rm_ready1", 32'(req1_if.ready), 32'd0);
    chk("rm_wen",    32'(mem_wen),       32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rm_hold_ready1", 32'(req1_if.ready), 32'd0);
    chk("rm_hold_wen",    32'(mem_wen),       32'd0);
    idle_reqs();
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("rm_no_restart", 32'(clear_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) if (mem[i] !== 16'h0) bad++;
    chk("rm_low_words_cleared", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 6; i < DEPTH; i++) if (mem[i] !== 16'hFFFF) bad++;
    chk("rm_high_words_kept", 32'(bad), 32'd0);

    // reset with a response in flight drops it
    set_req(0, 1'b1, 1'b0, 4'd1, 16'h0);
    @(negedge clock);
    idle_reqs();
    reset_n = 1'b0;
    #1;
    chk("rd_drop_rv0", 32'(req0_if.rsp_valid), 32'd0);
    chk("rd_drop_rd0", 32'(req0_if.rsp_rdata), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rd_drop_after", 32'(req0_if.rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
